rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// Shared instruction-ROM arbiter: round-robin read access for fetch and load units,
// plus a program-loader mode that drains reads and then grants ROM writes.
module rom_arbiter #(
    parameter int unsigned ROM_WORDS = 4096,
    parameter int unsigned AW        = 12
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req_i,
    input  logic [31:0]   if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [31:0]   if_rdata_o,

    input  logic          ls_req_i,
    input  logic [31:0]   ls_addr_i,
    output logic          ls_gnt_o,
    output logic          ls_rvalid_o,
    output logic [31:0]   ls_rdata_o,

    input  logic          ld_mode_i,
    input  logic          ld_req_i,
    input  logic [31:0]   ld_addr_i,
    input  logic [31:0]   ld_data_i,
    output logic          ld_gnt_o,
    output logic          ld_active_o,
    output logic [AW:0]   ld_cnt_o,

    output logic          rom_r_en_o,
    output logic [31:0]   rom_r_addr_o,
    input  logic [31:0]   rom_r_data_i,

    output logic          rom_w_en_o,
    output logic [31:0]   rom_w_addr_o,
    output logic [31:0]   rom_w_data_o
);

    if (ROM_WORDS > (64'd1 << AW)) begin : g_depth_check
        $error("rom_arbiter: ROM_WORDS does not fit in AW address bits");
    end

    typedef enum logic [1:0] {StRun, StDrain, StLoad} state_e;

    localparam logic [AW:0] CntMax = '1;
    localparam logic [AW:0] CntOne = {{AW{1'b0}}, 1'b1};

    state_e      state_q, state_d;
    logic        prio_ls_q, prio_ls_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic [AW:0] ld_cnt_q, ld_cnt_d;
    logic        ld_active_q, ld_active_d;

    logic        rd_ok;
    logic        if_gnt;
    logic        ls_gnt;
    logic        wr_gnt;

    // prio_ls_q set means the load unit wins the next tie.
    always_comb begin
        rd_ok  = !rst && (state_q == StRun) && !ld_mode_i;
        if_gnt = rd_ok && if_req_i && (!ls_req_i || !prio_ls_q);
        ls_gnt = rd_ok && ls_req_i && (!if_req_i || prio_ls_q);
        wr_gnt = !rst && (state_q == StLoad) && ld_mode_i && ld_req_i;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (ld_mode_i) state_d = StDrain;
            StDrain: state_d = StLoad;
            StLoad:  if (!ld_mode_i) state_d = StRun;
            default: state_d = StRun;
        endcase

        prio_ls_d = prio_ls_q;
        if (if_gnt) begin
            prio_ls_d = 1'b1;
        end else if (ls_gnt) begin
            prio_ls_d = 1'b0;
        end

        if_rvalid_d = if_gnt;
        ls_rvalid_d = ls_gnt;
        if_rdata_d  = if_rvalid_q ? rom_r_data_i : if_rdata_q;
        ls_rdata_d  = ls_rvalid_q ? rom_r_data_i : ls_rdata_q;

        ld_cnt_d = ld_cnt_q;
        if (state_q == StDrain) begin
            ld_cnt_d = '0;
        end else if (wr_gnt && (ld_cnt_q != CntMax)) begin
            ld_cnt_d = ld_cnt_q + CntOne;
        end

        ld_active_d = (state_d == StLoad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            prio_ls_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            ld_cnt_q    <= '0;
            ld_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_ls_q   <= prio_ls_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            ld_cnt_q    <= ld_cnt_d;
            ld_active_q <= ld_active_d;
        end
    end

    // Response data comes straight from the ROM in the rvalid cycle, otherwise the held copy.
    always_comb begin
        if_gnt_o     = if_gnt;
        ls_gnt_o     = ls_gnt;
        if_rvalid_o  = if_rvalid_q;
        ls_rvalid_o  = ls_rvalid_q;
        if_rdata_o   = if_rvalid_q ? rom_r_data_i : if_rdata_q;
        ls_rdata_o   = ls_rvalid_q ? rom_r_data_i : ls_rdata_q;

        rom_r_en_o   = if_gnt || ls_gnt;
        rom_r_addr_o = ls_gnt ? ls_addr_i : if_addr_i;

        ld_gnt_o     = wr_gnt;
        rom_w_en_o   = wr_gnt;
        rom_w_addr_o = ld_addr_i;
        rom_w_data_o = ld_data_i;

        ld_active_o  = ld_active_q;
        ld_cnt_o     = ld_cnt_q;
    end

endmodule
